// File: rtl/layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_mac_sequencer
// Brief    : Sequences one shared MAC and one activation unit over both
//            layers of the 30-5-3 network; holds hidden and output vectors.
// Revision : 1.0 - initial release
// ============================================================================
module layer_mac_sequencer #(
    parameter int N_IN  = 30,
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int DW    = 10,
    parameter int AW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  w_rd_en_o,
    output logic [AW-1:0]         w_addr_o,
    input  logic [DW-1:0]         w_data_i,
    output logic [4:0]            in_idx_o,
    input  logic [DW-1:0]         in_data_i,
    output logic                  mac_clr_o,
    output logic                  mac_en_o,
    output logic [DW-1:0]         mac_a_o,
    output logic [DW-1:0]         mac_b_o,
    input  logic [DW-1:0]         mac_acc_i,
    output logic                  act_req_o,
    output logic [DW-1:0]         act_in_o,
    input  logic                  act_ack_i,
    input  logic [DW-1:0]         act_out_i,
    output logic [N_HID*DW-1:0]   hid_vec_o,
    output logic [N_OUT*DW-1:0]   out_vec_o
);

    localparam int              C_NMAX     = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int              C_NW       = $clog2(C_NMAX + 1);
    localparam logic [4:0]      C_I_LAST   = 5'(N_IN - 1);
    localparam logic [4:0]      C_H_LAST   = 5'(N_HID - 1);
    localparam logic [C_NW-1:0] C_J_LAST   = C_NW'(N_HID - 1);
    localparam logic [C_NW-1:0] C_K_LAST   = C_NW'(N_OUT - 1);
    localparam logic [AW-1:0]   C_OUT_BASE = AW'(N_IN * N_HID);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HID_ISSUE = 3'd1,
        S_HID_DRAIN = 3'd2,
        S_HID_ACT   = 3'd3,
        S_OUT_ISSUE = 3'd4,
        S_OUT_DRAIN = 3'd5,
        S_OUT_ACT   = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           term_q, term_d;
    logic [C_NW-1:0]      nrn_q, nrn_d;
    logic                 drain_q, drain_d;
    logic                 vld_q, clr_q, sel_q;
    logic [DW-1:0]        hdly_q, hsel_d;
    logic [N_HID*DW-1:0]  hid_q, hid_d;
    logic [N_OUT*DW-1:0]  out_q, out_d;
    logic                 issue_d, out_layer_d;
    logic [AW-1:0]        addr_d;

    always_comb begin
        state_d     = state_q;
        term_d      = term_q;
        nrn_d       = nrn_q;
        drain_d     = 1'b0;
        hid_d       = hid_q;
        out_d       = out_q;
        issue_d     = 1'b0;
        out_layer_d = 1'b0;
        addr_d      = '0;
        hsel_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_HID_ISSUE;
                    term_d  = '0;
                    nrn_d   = '0;
                end
            end
            S_HID_ISSUE: begin
                issue_d = 1'b1;
                addr_d  = AW'(nrn_q) * AW'(N_IN) + AW'(term_q);
                if (term_q == C_I_LAST) begin
                    term_d  = '0;
                    state_d = S_HID_DRAIN;
                end else begin
                    term_d = term_q + 5'd1;
                end
            end
            // Two cycles: the last mac_en, then the accumulator settles.
            S_HID_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_HID_ACT;
            end
            S_HID_ACT: begin
                if (act_ack_i) begin
                    hid_d[int'(nrn_q) * DW +: DW] = act_out_i;
                    if (nrn_q == C_J_LAST) begin
                        nrn_d   = '0;
                        state_d = S_OUT_ISSUE;
                    end else begin
                        nrn_d   = nrn_q + C_NW'(1);
                        state_d = S_HID_ISSUE;
                    end
                end
            end
            S_OUT_ISSUE: begin
                issue_d     = 1'b1;
                out_layer_d = 1'b1;
                addr_d      = C_OUT_BASE + AW'(nrn_q) * AW'(N_HID) + AW'(term_q);
                hsel_d      = hid_q[int'(term_q) * DW +: DW];
                if (term_q == C_H_LAST) begin
                    term_d  = '0;
                    state_d = S_OUT_DRAIN;
                end else begin
                    term_d = term_q + 5'd1;
                end
            end
            S_OUT_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_OUT_ACT;
            end
            S_OUT_ACT: begin
                if (act_ack_i) begin
                    out_d[int'(nrn_q) * DW +: DW] = act_out_i;
                    if (nrn_q == C_K_LAST) begin
                        nrn_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        nrn_d   = nrn_q + C_NW'(1);
                        state_d = S_OUT_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            term_q  <= '0;
            nrn_q   <= '0;
            drain_q <= 1'b0;
            vld_q   <= 1'b0;
            clr_q   <= 1'b0;
            sel_q   <= 1'b0;
            hdly_q  <= '0;
            hid_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            nrn_q   <= nrn_d;
            drain_q <= drain_d;
            // Operand pipe: the read data arrives one cycle after the address.
            vld_q   <= issue_d;
            clr_q   <= issue_d & (term_q == 5'd0);
            sel_q   <= out_layer_d;
            hdly_q  <= hsel_d;
            hid_q   <= hid_d;
            out_q   <= out_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign w_rd_en_o = issue_d;
    assign w_addr_o  = addr_d;
    assign in_idx_o  = (state_q == S_HID_ISSUE) ? term_q : 5'd0;
    assign mac_en_o  = vld_q;
    assign mac_clr_o = clr_q;
    assign mac_a_o   = vld_q ? (sel_q ? hdly_q : in_data_i) : '0;
    assign mac_b_o   = vld_q ? w_data_i : '0;
    assign act_req_o = (state_q == S_HID_ACT) || (state_q == S_OUT_ACT);
    assign act_in_o  = act_req_o ? mac_acc_i : '0;
    assign hid_vec_o = hid_q;
    assign out_vec_o = out_q;

endmodule
`default_nettype wire
